// File: rtl/opm_pg_loop_pkg.sv
// Shared OPM constants and the phase-generator loop state encoding.
package opm_pg_loop_pkg;

    localparam int PH_W_DEF  = 20;
    localparam int OUT_W_DEF = 10;
    localparam int SLOTS_DEF = 32;
    localparam int SLOT_W    = $clog2(SLOTS_DEF);

    typedef enum logic [0:0] {
        ST_WIPE = 1'b0,
        ST_RUN  = 1'b1
    } pg_state_e;

endpackage

// File: rtl/opm_pg_loop_if.sv
// Slot-stream bundle between the frequency stage, the phase loop and the sine lookup.
interface opm_pg_loop_if
    import opm_pg_loop_pkg::*;
#(
    parameter int PH_W  = PH_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SLOTS = SLOTS_DEF
);
    localparam int SW = $clog2(SLOTS);

    logic             cen;
    logic             sync_in;
    logic [PH_W-1:0]  pinc;
    logic             kon_rst;
    logic             pg_test;
    logic [OUT_W-1:0] phase_out;
    logic [SW-1:0]    slot_out;
    logic             ready;
    logic             sync_err;

    modport master (
        output cen, sync_in, pinc, kon_rst, pg_test,
        input  phase_out, slot_out, ready, sync_err
    );

    modport slave (
        input  cen, sync_in, pinc, kon_rst, pg_test,
        output phase_out, slot_out, ready, sync_err
    );

endinterface

// File: rtl/opm_pg_loop_ebr_sh.sv
// Block-RAM delay line: a circular buffer whose output is the word written STAGES cen cycles ago.
module ebr_sh #(
    parameter int WIDTH  = 20,
    parameter int STAGES = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(STAGES - 1);

    logic [WIDTH-1:0] mem_q [STAGES];
    logic [AW-1:0]    ptr_q;
    logic [AW-1:0]    ptr_d;

    // Next pointer: advance on cen, wrap at the last stage.
    always_comb begin
        ptr_d = ptr_q;
        if (rst) begin
            ptr_d = '0;
        end else if (cen) begin
            if (ptr_q == PTR_LAST) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + AW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        ptr_q <= ptr_d;
    end

    // RAM write; the read of the same word happens combinationally before it is replaced.
    always_ff @(posedge clk) begin
        if (cen) begin
            mem_q[ptr_q] <= din;
        end
    end

    assign dout = mem_q[ptr_q];

endmodule

// File: rtl/opm_pg_loop.sv
// OPM phase-generator accumulation loop: 32 time-multiplexed phase accumulators
// recirculating through ph_q plus a SLOTS-1 deep RAM delay line.
module opm_pg_loop
    import opm_pg_loop_pkg::*;
#(
    parameter int PH_W  = PH_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SLOTS = SLOTS_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    opm_pg_loop_if.slave bus
);
    localparam int SW = $clog2(SLOTS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

    pg_state_e        state_q, state_d;
    logic [SW-1:0]    slot_cnt_q, slot_cnt_d;
    logic [SW-1:0]    wipe_cnt_q, wipe_cnt_d;
    logic [SW-1:0]    slot_out_q, slot_out_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [OUT_W-1:0] phase_out_q, phase_out_d;
    logic             ready_q, ready_d;
    logic             sync_err_q, sync_err_d;
    logic [PH_W-1:0]  cur_s;
    logic [PH_W-1:0]  nxt_s;
    logic [SW-1:0]    slot_cur_s;

    // Clearing of the RAM contents is done by the WIPE pass, so its own reset stays idle.
    ebr_sh #(
        .WIDTH  (PH_W),
        .STAGES (SLOTS - 1)
    ) u_dly (
        .clk  (clk),
        .rst  (1'b0),
        .cen  (bus.cen),
        .din  (ph_q),
        .dout (cur_s)
    );

    // Next-state: slot labelling, wipe sequencing and the phase add.
    always_comb begin
        state_d     = state_q;
        slot_cnt_d  = slot_cnt_q;
        wipe_cnt_d  = wipe_cnt_q;
        ph_d        = ph_q;
        phase_out_d = phase_out_q;
        slot_out_d  = slot_out_q;
        ready_d     = ready_q;
        sync_err_d  = sync_err_q;
        // A sync pulse means slot 0 is on the inputs right now, whatever the counter says.
        slot_cur_s  = bus.sync_in ? '0 : slot_cnt_q;
        nxt_s       = (bus.kon_rst || bus.pg_test) ? '0 : (cur_s + bus.pinc);

        if (bus.cen) begin
            if (bus.sync_in) begin
                slot_cnt_d = SW'(1);
            end else begin
                slot_cnt_d = slot_cnt_q + SW'(1);
            end

            if (bus.sync_in && (slot_cnt_q != '0)) begin
                sync_err_d = 1'b1;
            end else begin
                sync_err_d = sync_err_q;
            end

            case (state_q)
                ST_WIPE: begin
                    ph_d        = '0;
                    phase_out_d = '0;
                    ready_d     = 1'b0;
                    if (wipe_cnt_q == LAST_SLOT) begin
                        state_d    = ST_RUN;
                        ready_d    = 1'b1;
                        wipe_cnt_d = '0;
                    end else begin
                        wipe_cnt_d = wipe_cnt_q + SW'(1);
                    end
                end
                ST_RUN: begin
                    ph_d        = nxt_s;
                    phase_out_d = nxt_s[PH_W-1 -: OUT_W];
                    slot_out_d  = slot_cur_s;
                end
                default: begin
                    state_d     = ST_WIPE;
                    wipe_cnt_d  = '0;
                    ph_d        = '0;
                    phase_out_d = '0;
                    ready_d     = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_WIPE;
            slot_cnt_q  <= '0;
            wipe_cnt_q  <= '0;
            ph_q        <= '0;
            phase_out_q <= '0;
            slot_out_q  <= '0;
            ready_q     <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_cnt_q  <= slot_cnt_d;
            wipe_cnt_q  <= wipe_cnt_d;
            ph_q        <= ph_d;
            phase_out_q <= phase_out_d;
            slot_out_q  <= slot_out_d;
            ready_q     <= ready_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign bus.phase_out = phase_out_q;
    assign bus.slot_out  = slot_out_q;
    assign bus.ready     = ready_q;
    assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_opm_pg_loop.sv
// Bench for opm_pg_loop: a queue-based loop model checked every negedge, plus literal spot checks.
module tb_opm_pg_loop;
    import opm_pg_loop_pkg::*;

    localparam int PH_W  = 20;
    localparam int OUT_W = 10;
    localparam int SLOTS = 32;
    localparam logic [PH_W-1:0] INC = 20'h00400;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    opm_pg_loop_if #(.PH_W(PH_W), .OUT_W(OUT_W), .SLOTS(SLOTS)) bus ();

    opm_pg_loop #(.PH_W(PH_W), .OUT_W(OUT_W), .SLOTS(SLOTS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the loop is a FIFO of SLOTS phases; each cen pops the current slot and pushes its update.
    logic [PH_W-1:0]  mq [$];
    int               m_cnt;
    int               m_wipe;
    bit               m_run;
    logic [OUT_W-1:0] exp_phase;
    logic [4:0]       exp_slot;
    bit               exp_ready;
    bit               exp_err;

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < SLOTS; i++) mq.push_back('0);
        m_cnt = 0; m_wipe = 0; m_run = 1'b0;
        exp_phase = '0; exp_slot = '0; exp_ready = 1'b0; exp_err = 1'b0;
    endfunction

    function automatic void model_step();
        logic [PH_W-1:0] cur, nxt;
        int lab;
        lab = bus.sync_in ? 0 : m_cnt;
        if (bus.sync_in && m_cnt != 0) exp_err = 1'b1;
        m_cnt = bus.sync_in ? 1 : (m_cnt + 1) % SLOTS;
        cur = mq.pop_front();
        if (!m_run) begin
            mq.push_back('0);
            exp_phase = '0;
            m_wipe++;
            if (m_wipe == SLOTS) begin
                m_run = 1'b1;
                exp_ready = 1'b1;
            end
        end else begin
            if (bus.kon_rst || bus.pg_test) nxt = '0;
            else nxt = PH_W'((int'(cur) + int'(bus.pinc)) % (1 << PH_W));
            mq.push_back(nxt);
            exp_phase = OUT_W'(nxt >> (PH_W - OUT_W));
            exp_slot  = 5'(lab);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("phase_out", 32'(bus.phase_out), 32'(exp_phase));
        check("ready", 32'(bus.ready), 32'(exp_ready));
        check("sync_err", 32'(bus.sync_err), 32'(exp_err));
        if (exp_ready) check("slot_out", 32'(bus.slot_out), 32'(exp_slot));
    end

    task automatic cyc();
        @(posedge clk);
        if (rst_n && bus.cen) model_step();
        #2;
    endtask

    task automatic gap();
        int len;
        len = $urandom_range(1, 7);
        for (int g = 0; g < len; g++) begin
            bus.cen = 1'b0;
            bus.sync_in = 1'($urandom_range(0, 1));
            bus.kon_rst = 1'($urandom_range(0, 1));
            bus.pinc = PH_W'($urandom);
            cyc();
        end
    endtask

    task automatic run_pass(input logic [PH_W-1:0] pinc, input int kon_slot, input bit pg,
                            input int chk_slot, input int chk_val, input bit gaps);
        for (int i = 0; i < SLOTS; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) gap();
            bus.cen = 1'b1; bus.sync_in = (i == 0); bus.pinc = pinc;
            bus.kon_rst = (i == kon_slot); bus.pg_test = pg;
            cyc();
            if (i == chk_slot) begin
                check("lit_phase", 32'(bus.phase_out), 32'(chk_val));
                check("lit_model", 32'(exp_phase), 32'(chk_val));
                check("lit_slot", 32'(bus.slot_out), 32'(i));
            end
        end
        bus.sync_in = 1'b0; bus.kon_rst = 1'b0; bus.pg_test = 1'b0;
    endtask

    task automatic wipe_seq();
        for (int i = 0; i < SLOTS; i++) begin
            bus.cen = 1'b1; bus.sync_in = (i == 0); bus.pinc = INC;
            cyc();
            check("wipe_ready", 32'(bus.ready), (i == SLOTS - 1) ? 32'd1 : 32'd0);
        end
        bus.sync_in = 1'b0;
    endtask

    initial begin
        model_reset();
        bus.cen = 1'b0; bus.sync_in = 1'b0; bus.pinc = '0;
        bus.kon_rst = 1'b0; bus.pg_test = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Wipe, then a zero-increment pass.
        wipe_seq();
        run_pass('0, -1, 1'b0, 4, 0, 1'b0);

        // Accumulation through the full 10-bit wrap.
        run_pass(INC, -1, 1'b0, 7, 1, 1'b0);
        run_pass(INC, -1, 1'b0, 0, 2, 1'b0);
        for (int p = 3; p < 1023; p++) run_pass(INC, -1, 1'b0, -1, 0, 1'b0);
        run_pass(INC, -1, 1'b0, 31, 1023, 1'b0);
        run_pass(INC, -1, 1'b0, 12, 0, 1'b0);

        // Key-on of slot 5 on pass 10.
        for (int p = 1; p < 10; p++) run_pass(INC, -1, 1'b0, -1, 0, 1'b0);
        run_pass(INC, 5, 1'b0, 5, 0, 1'b0);
        run_pass(INC, -1, 1'b0, 5, 1, 1'b0);
        check("kon_other", 32'(bus.phase_out), 32'd11);

        // pg_test together with kon_rst, then resume.
        run_pass(INC, 9, 1'b1, 9, 0, 1'b0);
        run_pass(INC, -1, 1'b0, 3, 1, 1'b0);

        // cen gaps.
        run_pass(INC, -1, 1'b0, -1, 0, 1'b1);
        run_pass(INC, -1, 1'b0, -1, 0, 1'b1);
        run_pass(INC, -1, 1'b0, 31, 4, 1'b1);

        // Misaligned sync at slot 17.
        for (int i = 0; i < 17; i++) begin
            bus.cen = 1'b1; bus.sync_in = (i == 0); bus.pinc = INC;
            cyc();
        end
        bus.sync_in = 1'b1;
        cyc();
        check("mis_err", 32'(bus.sync_err), 32'd1);
        check("mis_slot", 32'(bus.slot_out), 32'd0);
        check("mis_phase", 32'(bus.phase_out), 32'd5);
        bus.sync_in = 1'b0;
        for (int i = 1; i < SLOTS; i++) cyc();
        run_pass(INC, -1, 1'b0, 0, 6, 1'b0);
        run_pass(INC, -1, 1'b0, 20, 8, 1'b0);
        check("err_sticky", 32'(bus.sync_err), 32'd1);

        // Reset during pass 20.
        for (int p = 1; p < 20; p++) run_pass(INC, -1, 1'b0, -1, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus.cen = 1'b1; bus.sync_in = (i == 0); bus.pinc = INC;
            cyc();
        end
        bus.sync_in = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_phase", 32'(bus.phase_out), 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_err", 32'(bus.sync_err), 32'd0);
        check("rst_slot", 32'(bus.slot_out), 32'd0);
        cyc();
        rst_n = 1'b1;
        wipe_seq();
        run_pass(INC, -1, 1'b0, 3, 1, 1'b0);

        bus.cen = 1'b0;
        repeat (2) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/opm_pg_loop.md
Name: opm_pg_loop

Overview:
- Phase-generator accumulation stage of the OPM core, time-multiplexed over 32 operator slots, one slot per cen cycle.
- Holds each slot's phase accumulator in a block-RAM recirculating delay line; the loop latency is exactly SLOTS cen cycles.
- Each pass adds the slot's phase increment, which comes from the upstream frequency stage.
- Presents the top phase bits to the downstream operator/sine-lookup stage.

Parameters:
- PH_W, 20, phase accumulator width.
- OUT_W, 10, phase bits forwarded downstream; these are the MSBs of the accumulator.
- SLOTS, 32, number of time-multiplexed slots. Power of two, ≥4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cen  in  1  clock enable; one slot is processed per cen cycle.
- sync_in  in  1  qualified by cen; marks the cycle in which slot 0 is presented on the inputs.
- pinc  in  PH_W  phase increment for the slot currently presented.
- kon_rst  in  1  forces the current slot's phase to 0 on this pass (key-on).
- pg_test  in  1  forces all slots' phases to 0 while high.
- phase_out  out  OUT_W  updated phase MSBs of the slot given on slot_out.
- slot_out  out  $clog2(SLOTS)  slot index associated with phase_out.
- ready  out  1  high once the post-reset wipe has completed.
- sync_err  out  1  sticky flag: sync_in arrived while slot_cnt was not 0.

Behaviour:
- Reset is asynchronous and active-low; clock is clk. rst_n=0 clears:
  - phase_out=0, slot_out=0, ready=0, sync_err=0;
  - slot_cnt=0, wipe_cnt=0, ph_q=0;
  - FSM goes to WIPE.
- When cen=0, all state holds. Nothing advances and nothing is written.
- Slot counter, updated on each cen:
  - sync_in=1: slot_cnt <= 1, because slot 0 is being processed this cycle.
  - otherwise: slot_cnt <= slot_cnt+1, wrapping SLOTS-1 -> 0.
- sync_err:
  - set on any cen with sync_in=1 and slot_cnt≠0;
  - cleared only by reset;
  - set in both WIPE and RUN.
- Loop structure:
  - The delay line is width PH_W and depth SLOTS-1.
  - Its output cur is the stored phase of slot slot_cnt.
  - ph_q is the loop register and feeds the delay-line input.
  - Total loop latency = SLOTS cen cycles.
- FSM WIPE:
  - Lasts exactly SLOTS cen cycles, counted by wipe_cnt.
  - Each cen writes ph_q <= 0, so the delay line fills with zeros.
  - phase_out=0, ready=0. slot_cnt still runs normally.
  - After the SLOTS-th cen: go to RUN and set ready=1 in the same clock edge.
- FSM RUN, on each cen:
  - nxt = (kon_rst | pg_test) ? 0 : (cur + pinc) mod 2^PH_W. Carry is discarded; no saturation.
  - ph_q <= nxt.
  - phase_out <= nxt[PH_W-1 -: OUT_W].
  - slot_out <= slot_cnt.
  - Latency from inputs to phase_out/slot_out: 1 cen cycle.
- Simultaneous kon_rst and pg_test: result is 0, same as either alone.
- sync_in re-alignment: only relabels slot_cnt. Stored phases are not moved or cleared.
- Reset mid-operation: state is asynchronously cleared and a full WIPE is redone.
- There are no RUN states other than WIPE and RUN; RUN is left only via reset.

Decomposition:
- Shared OPM package holds:
  - SLOTS and PH_W defaults;
  - the slot-index width constant;
  - FSM state encoding {WIPE, RUN}.
- One sub-module: the existing block-RAM shift register ebr_sh, instantiated with width=PH_W, stages=SLOTS-1.
  - Its own rst is tied low; clearing is done by this block's WIPE.
  - Its cen is tied to cen.
- Everything else (counters, FSM, adder, output registers) lives inline in opm_pg_loop.

Test Plan:
- Reset/wipe: release rst_n, cen=1 continuously.
  - ready=0 for exactly 32 cen cycles, then 1.
  - phase_out=0 throughout WIPE.
  - With pinc=0, phase_out stays 0 in RUN.
- Accumulation: sync_in on slot 0, pinc=0x00400 for all slots.
  - After the n-th pass, every slot's phase_out = n.
  - After 1023 passes, the next pass gives 0 (wrap 0xFFC00+0x400=0x100000 -> 0).
- Per-slot key-on: pinc=0x00400, pulse kon_rst only when slot_cnt=5 during pass 10.
  - Slot 5 phase_out=0 on pass 10 and 1 on pass 11.
  - Other slots read 10 and 11.
- cen gating: insert random cen=0 gaps of 1–7 cycles.
  - phase_out sequence per slot is identical to the gap-free run.
  - Outputs hold during gaps.
- sync misalignment: assert sync_in while slot_cnt=17.
  - sync_err goes to 1 and stays 1.
  - slot_out is 0 on the next output.
  - Stored phases keep accumulating by 1 per pass.
- Reset mid-RUN: drop rst_n for 1 clk during pass 20.
  - Outputs go to 0 immediately, without waiting for a clk edge.
  - WIPE repeats for 32 cen cycles.
  - The first RUN pass with pinc=0x00400 gives phase_out=1.
